// File: rtl/divider_seq.sv
// Multicycle radix-2 restoring divider, signed or unsigned, one quotient bit per cycle.
// Start/busy/done handshake; results are held until the next division finishes.
module divider_seq #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_signed,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quot,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_div0
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] wquot_q, wquot_d;   // dividend shifts out, quotient bits shift in
   logic [WIDTH-1:0] wrem_q, wrem_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] araw_q, araw_d;
   logic             qneg_q, qneg_d, rneg_q, rneg_d, zdiv_q, zdiv_d;
   logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
   logic             div0_q, div0_d;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   shifted, diff;

   always_comb begin
      a_neg   = i_signed & i_a[WIDTH-1];
      b_neg   = i_signed & i_b[WIDTH-1];
      a_mag   = a_neg ? (~i_a + WIDTH'(1)) : i_a;
      b_mag   = b_neg ? (~i_b + WIDTH'(1)) : i_b;
      // Extra top bit keeps the trial subtraction's borrow visible.
      shifted = {wrem_q, wquot_q[WIDTH-1]};
      diff    = shifted - {1'b0, b_q};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wquot_d = wquot_q;
      wrem_d  = wrem_q;
      b_d     = b_q;
      araw_d  = araw_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      zdiv_d  = zdiv_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      div0_d  = div0_q;
      case (state_q)
         IDLE, DONE: begin
            if (i_start) begin
               wquot_d = a_mag;
               b_d     = b_mag;
               araw_d  = i_a;
               qneg_d  = a_neg ^ b_neg;
               rneg_d  = a_neg;
               zdiv_d  = (i_b == '0);
               wrem_d  = '0;
               cnt_d   = CW'(WIDTH);
               state_d = CALC;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         CALC: begin
            wrem_d  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            wquot_d = {wquot_q[WIDTH-2:0], ~diff[WIDTH]};
            cnt_d   = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = FIX;
         end
         FIX: begin
            quot_d  = qneg_q ? (~wquot_q + WIDTH'(1)) : wquot_q;
            rem_d   = rneg_q ? (~wrem_q + WIDTH'(1)) : wrem_q;
            if (zdiv_q) begin
               quot_d = '1;
               rem_d  = araw_q;
            end
            div0_d  = zdiv_q;
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wquot_q <= '0;
         wrem_q  <= '0;
         b_q     <= '0;
         araw_q  <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         zdiv_q  <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         div0_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wquot_q <= wquot_d;
         wrem_q  <= wrem_d;
         b_q     <= b_d;
         araw_q  <= araw_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         zdiv_q  <= zdiv_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         div0_q  <= div0_d;
      end
   end

   assign o_busy = (state_q == CALC) || (state_q == FIX);
   assign o_done = (state_q == DONE);
   assign o_quot = quot_q;
   assign o_rem  = rem_q;
   assign o_div0 = div0_q;
endmodule

// File: tb/tb_divider_seq.sv
// Random and directed divisions checked against a plain-arithmetic reference,
// including latency, busy length, ignored starts, restart in DONE and mid-op reset.
module tb_divider_seq;
   logic        clk = 1'b0;
   logic        rst, start, sgn, busy, done, div0;
   logic [31:0] a, b, quot, rem;

   divider_seq #(.WIDTH(32)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_signed(sgn),
      .i_a(a), .i_b(b), .o_busy(busy), .o_done(done),
      .o_quot(quot), .o_rem(rem), .o_div0(div0)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q, exp_r, prev_q, prev_r;
   logic        exp_z, prev_z;
   int          inject_at;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic void model(input logic [31:0] ma, input logic [31:0] mb, input logic ms,
                                 output logic [31:0] q, output logic [31:0] r, output logic z);
      longint sa, sb;
      z = (mb == 0);
      if (z) begin
         q = 32'hFFFF_FFFF;
         r = ma;
      end else if (ms) begin
         sa = longint'($signed(ma));
         sb = longint'($signed(mb));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end else begin
         q = ma / mb;
         r = ma % mb;
      end
   endfunction

   // Present a request; accepted on the next rising edge.
   task automatic start_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts);
      prev_q = quot; prev_r = rem; prev_z = div0;
      model(ta, tb, ts, exp_q, exp_r, exp_z);
      start = 1'b1; a = ta; b = tb; sgn = ts;
   endtask

   // Wait for the accepting edge, then for o_done; checks latency, busy length, hold and results.
   task automatic finish_op(input string tag);
      int edges, nbusy;
      @(posedge clk); #1;
      start = 1'b0; a = $urandom; b = $urandom; sgn = 1'($urandom);
      edges = 1; nbusy = 0;
      while (!done && edges < 100) begin
         if (busy) nbusy++;
         if (edges == 5) chk({tag, "_hold_q"}, quot, prev_q);
         start = (edges == inject_at);
         if (edges == inject_at) begin a = 9; b = 3; sgn = 1'b0; end
         @(posedge clk); #1;
         edges++;
      end
      start = 1'b0;
      chk({tag, "_lat"},  32'(edges), 32'd34);
      chk({tag, "_busy"}, 32'(nbusy), 32'd33);
      chk({tag, "_q"},    quot, exp_q);
      chk({tag, "_r"},    rem,  exp_r);
      chk({tag, "_z"},    {31'd0, div0}, {31'd0, exp_z});
   endtask

   task automatic run(input logic [31:0] ta, input logic [31:0] tb, input logic ts, input string tag);
      @(negedge clk);
      start_op(ta, tb, ts);
      finish_op(tag);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0; inject_at = -1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_q", quot, 32'd0);
      chk("rst_r", rem, 32'd0);
      chk("rst_z", {31'd0, div0}, 32'd0);
      rst = 1'b0;

      run(100, 7, 1'b0, "u100_7");
      run(32'hFFFF_FFF9, 2, 1'b1, "s_m7_2");
      run(7, 32'hFFFF_FFFE, 1'b1, "s_7_m2");
      run(5, 0, 1'b0, "u5_0");
      run(5, 0, 1'b1, "s5_0");
      run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_ovf");
      run(32'hFFFF_FFFF, 1, 1'b0, "u_max_1");

      // A start while busy is ignored; then restart straight from the DONE cycle.
      inject_at = 10;
      run(100, 7, 1'b0, "ign");
      inject_at = -1;
      chk("ign_done", {31'd0, done}, 32'd1);
      start_op(9, 3, 1'b0);
      finish_op("done_restart");

      // Reset in the middle of a division.
      @(negedge clk);
      start_op(100, 7, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mrst_busy", {31'd0, busy}, 32'd0);
      chk("mrst_q", quot, 32'd0);
      chk("mrst_r", rem, 32'd0);
      chk("mrst_z", {31'd0, div0}, 32'd0);
      begin
         int seen = 0;
         repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
         end
         chk("mrst_nodone", 32'(seen), 32'd0);
      end
      run(20, 6, 1'b0, "post_rst");

      for (int i = 0; i < 40; i++) begin
         logic [31:0] ra, rb;
         logic        rs;
         ra = $urandom;
         case ($urandom_range(0, 3))
            0: rb = 32'($urandom_range(0, 15));
            1: rb = 32'($signed(-$urandom_range(1, 15)));
            default: rb = $urandom >> $urandom_range(0, 31);
         endcase
         rs = 1'($urandom);
         run(ra, rb, rs, $sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
